// File: rtl/lfsr_rr_scheduler.sv
// lfsr_rr_scheduler: one shared LFSR serving NUM_REQ requesters round-robin.
// Optional macro LFSR_SCHED_RESEED_EN adds automatic reseed every RESEED_WORDS words.

module lfsr_rr_lfsr #(
  parameter int NUM_BITS = 16
) (
  input  logic                i_Clk,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_Next
);

  function automatic logic [31:0] f_taps(input int n);
    logic [31:0] t;
    case (n)
      3:       t = 32'h0000_0006;
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      32:      t = 32'h8020_0003;
      default: t = 32'h0000_0006;
    endcase
    return t;
  endfunction

  localparam logic [NUM_BITS-1:0] TAPS =
    NUM_BITS'(f_taps(NUM_BITS));

  logic [NUM_BITS-1:0] r_LFSR;
  logic                w_Fb;

  // XNOR feedback: all-ones is the lock-up state
  assign w_Fb   = ~^(r_LFSR & TAPS);
  assign o_Next = {r_LFSR[NUM_BITS-2:0], w_Fb};

  // Shift register, deliberately without reset
  always_ff @(posedge i_Clk) begin
    if (i_Enable) begin
      if (i_Seed_DV) r_LFSR <= i_Seed_Data;
      else           r_LFSR <= o_Next;
    end
  end

endmodule

module lfsr_rr_scheduler #(
  parameter int NUM_BITS       = 16,
  parameter int NUM_REQ        = 4,
  parameter int STEPS_PER_WORD = 16,
  parameter int WARMUP_STEPS   = 32,
  parameter int RESEED_WORDS   = 1024
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Seed_Req,
  input  logic [NUM_BITS-1:0] i_Seed,
  input  logic [NUM_REQ-1:0]  i_Req,
  input  logic [NUM_REQ-1:0]  i_Ready,
  output logic [NUM_REQ-1:0]  o_Valid,
  output logic [NUM_BITS-1:0] o_Data,
  output logic                o_Busy,
  output logic                o_Seeded
);

  if (NUM_BITS < 3 || NUM_BITS > 32) begin : g_bad_bits
    $error("NUM_BITS out of range");
  end
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_req
    $error("NUM_REQ out of range");
  end
  if (STEPS_PER_WORD < 1 || STEPS_PER_WORD > 255) begin : g_bad_steps
    $error("STEPS_PER_WORD out of range");
  end
  if (WARMUP_STEPS < 0) begin : g_bad_warm
    $error("WARMUP_STEPS negative");
  end
  if (RESEED_WORDS < 1) begin : g_bad_reseed
    $error("RESEED_WORDS must be positive");
  end

  localparam int PW = $clog2(NUM_REQ);
  localparam int CNT_MAX = (WARMUP_STEPS > STEPS_PER_WORD) ?
                           WARMUP_STEPS : STEPS_PER_WORD;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEPS_PER_WORD - 1);
  localparam logic [CW-1:0] WARM_LAST =
    CW'((WARMUP_STEPS > 0) ? WARMUP_STEPS - 1 : 0);

  typedef enum logic [2:0] {
    SEED_WAIT,
    SEED,
    WARMUP,
    ARB,
    STEP,
    PRESENT
  } state_t;

  state_t r_State, w_State_Nxt;

  logic [CW-1:0]       r_Cnt;
  logic [PW-1:0]       r_Ptr;
  logic [PW-1:0]       r_Grant;
  logic [NUM_BITS-1:0] r_Data;
  logic                r_Seeded;

  logic                w_Lfsr_En;
  logic                w_Seed_Dv;
  logic [NUM_BITS-1:0] w_Seed_Data;
  logic [NUM_BITS-1:0] w_Lfsr_Next;
  logic                w_Cnt_Clr;
  logic                w_Cnt_Inc;
  logic                w_Grant_Ld;
  logic                w_Ptr_Adv;
  logic                w_Data_Ld;
  logic                w_Seeded_Set;
  logic [PW:0]         w_Pick;
  logic [PW-1:0]       w_Ptr_Next;

  function automatic logic [PW:0] f_rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [PW-1:0]      ptr
  );
    logic [PW:0] res;
    int          k;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (req[k]) res = {1'b1, PW'(k)};
    end
    return res;
  endfunction

  assign w_Pick = f_rr_pick(i_Req, r_Ptr);
  assign w_Ptr_Next = (r_Grant == PW'(NUM_REQ - 1)) ?
                      '0 : r_Grant + PW'(1);

`ifdef LFSR_SCHED_RESEED_EN
  localparam int WCW = $clog2(RESEED_WORDS + 1);
  localparam logic [WCW-1:0] WC_MAX = WCW'(RESEED_WORDS);

  logic [WCW-1:0]      r_Word_Cnt;
  logic                r_Auto;
  logic                w_Auto_Nxt;
  logic                w_Word_Inc;
  logic                w_Word_Clr;
  logic [NUM_BITS-1:0] w_Mix;

  // Auto reseed mixes the last word into the user seed
  assign w_Mix = r_Data ^ i_Seed;
  assign w_Seed_Data = !r_Auto ? i_Seed :
                       (w_Mix == '0) ? i_Seed : w_Mix;
`else
  assign w_Seed_Data = i_Seed;
`endif

  lfsr_rr_lfsr #(
    .NUM_BITS    (NUM_BITS)
  ) u_lfsr (
    .i_Clk       (i_Clk),
    .i_Enable    (w_Lfsr_En),
    .i_Seed_DV   (w_Seed_Dv),
    .i_Seed_Data (w_Seed_Data),
    .o_Next      (w_Lfsr_Next)
  );

  // FSM state register
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) r_State <= SEED_WAIT;
    else          r_State <= w_State_Nxt;
  end

  // Next-state and control strobes
  always_comb begin
    w_State_Nxt  = r_State;
    w_Lfsr_En    = 1'b0;
    w_Seed_Dv    = 1'b0;
    w_Cnt_Clr    = 1'b0;
    w_Cnt_Inc    = 1'b0;
    w_Grant_Ld   = 1'b0;
    w_Ptr_Adv    = 1'b0;
    w_Data_Ld    = 1'b0;
    w_Seeded_Set = 1'b0;
`ifdef LFSR_SCHED_RESEED_EN
    w_Auto_Nxt   = r_Auto;
    w_Word_Inc   = 1'b0;
    w_Word_Clr   = 1'b0;
`endif
    unique case (r_State)
      SEED_WAIT: begin
        if (i_Seed_Req) w_State_Nxt = SEED;
      end
      SEED: begin
        w_Lfsr_En = 1'b1;
        w_Seed_Dv = 1'b1;
        w_Cnt_Clr = 1'b1;
`ifdef LFSR_SCHED_RESEED_EN
        w_Word_Clr = 1'b1;
`endif
        if (i_Seed_Req) begin
          w_State_Nxt = SEED;
        end else if (WARMUP_STEPS == 0) begin
          w_State_Nxt  = ARB;
          w_Seeded_Set = 1'b1;
        end else begin
          w_State_Nxt = WARMUP;
        end
      end
      WARMUP: begin
        if (i_Seed_Req) begin
          w_State_Nxt = SEED;
        end else begin
          w_Lfsr_En = 1'b1;
          w_Cnt_Inc = 1'b1;
          if (r_Cnt == WARM_LAST) begin
            w_Cnt_Clr    = 1'b1;
            w_Seeded_Set = 1'b1;
            w_State_Nxt  = ARB;
          end
        end
      end
      ARB: begin
        if (i_Seed_Req) begin
          w_State_Nxt = SEED;
`ifdef LFSR_SCHED_RESEED_EN
        end else if (r_Word_Cnt == WC_MAX) begin
          w_State_Nxt = SEED;
          w_Auto_Nxt  = 1'b1;
`endif
        end else if (w_Pick[PW]) begin
          w_Grant_Ld  = 1'b1;
          w_Cnt_Clr   = 1'b1;
          w_State_Nxt = STEP;
        end
      end
      STEP: begin
        if (i_Seed_Req) begin
          w_State_Nxt = SEED;
        end else begin
          w_Lfsr_En = 1'b1;
          w_Cnt_Inc = 1'b1;
          if (r_Cnt == STEP_LAST) begin
            w_Cnt_Clr   = 1'b1;
            w_Data_Ld   = 1'b1;
            w_State_Nxt = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (i_Seed_Req) begin
          w_State_Nxt = SEED;
        end else if (i_Ready[r_Grant]) begin
          w_Ptr_Adv   = 1'b1;
          w_State_Nxt = ARB;
`ifdef LFSR_SCHED_RESEED_EN
          w_Word_Inc  = 1'b1;
`endif
        end
      end
      default: w_State_Nxt = SEED_WAIT;
    endcase
`ifdef LFSR_SCHED_RESEED_EN
    if (i_Seed_Req) w_Auto_Nxt = 1'b0;
`endif
  end

  // Step counter, grant, pointer, word and seeded flag
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Cnt    <= '0;
      r_Ptr    <= '0;
      r_Grant  <= '0;
      r_Data   <= '0;
      r_Seeded <= 1'b0;
    end else begin
      if (w_Cnt_Clr)      r_Cnt <= '0;
      else if (w_Cnt_Inc) r_Cnt <= r_Cnt + CW'(1);
      if (w_Grant_Ld)     r_Grant <= w_Pick[PW-1:0];
      if (w_Ptr_Adv)      r_Ptr <= w_Ptr_Next;
      if (w_Data_Ld)      r_Data <= w_Lfsr_Next;
      if (w_Seeded_Set)   r_Seeded <= 1'b1;
    end
  end

`ifdef LFSR_SCHED_RESEED_EN
  // Saturating word counter and auto-seed flag
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Word_Cnt <= '0;
      r_Auto     <= 1'b0;
    end else begin
      r_Auto <= w_Auto_Nxt;
      if (w_Word_Clr)
        r_Word_Cnt <= '0;
      else if (w_Word_Inc && r_Word_Cnt != WC_MAX)
        r_Word_Cnt <= r_Word_Cnt + WCW'(1);
    end
  end
`endif

  assign o_Valid  = (r_State == PRESENT) ?
                    (NUM_REQ'(1) << r_Grant) : '0;
  assign o_Data   = r_Data;
  assign o_Busy   = (r_State == SEED) ||
                    (r_State == WARMUP) ||
                    (r_State == STEP);
  assign o_Seeded = r_Seeded;

endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// tb_lfsr_rr_scheduler: directed bench for lfsr_rr_scheduler.
// Golden 16-bit XNOR LFSR (taps 16,15,13,4) predicts every word.

module tb_lfsr_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic        seed_req;
  logic [15:0] seed;
  logic [3:0]  req;
  logic [3:0]  rdy;
  logic [3:0]  valid;
  logic [15:0] data;
  logic        busy;
  logic        seeded;

  int checks = 0;
  int errors = 0;

  lfsr_rr_scheduler #(
    .NUM_BITS       (16),
    .NUM_REQ        (4),
    .STEPS_PER_WORD (16),
    .WARMUP_STEPS   (32),
    .RESEED_WORDS   (4)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_n    (rst_n),
    .i_Seed_Req (seed_req),
    .i_Seed     (seed),
    .i_Req      (req),
    .i_Ready    (rdy),
    .o_Valid    (valid),
    .o_Data     (data),
    .o_Busy     (busy),
    .o_Seeded   (seeded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] m_state;
  logic [15:0] m_last;
  logic [15:0] m_seed;
  int          m_words;

  function automatic logic [15:0] step16(input logic [15:0] x);
    return {x[14:0], ~(x[15] ^ x[14] ^ x[12] ^ x[3])};
  endfunction

  task automatic m_load(input logic [15:0] s);
    m_state = s;
    repeat (32) m_state = step16(m_state);
    m_words = 0;
  endtask

  task automatic m_next(output logic [15:0] w);
    logic [15:0] s;
`ifdef LFSR_SCHED_RESEED_EN
    if (m_words == 4) begin
      s = m_last ^ m_seed;
      if (s == 16'h0) s = m_seed;
      m_load(s);
    end
`endif
    s = 16'h0;
    repeat (16) m_state = step16(m_state);
    w = m_state;
    m_last = m_state;
    m_words++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic get_word(output logic [3:0] v,
                          output logic [15:0] d,
                          output int t,
                          output int nb);
    t = 0;
    nb = 0;
    do begin
      tick();
      t++;
      if (valid == 4'h0 && busy) nb++;
    end while (valid == 4'h0 && t < 300);
    v = valid;
    d = data;
  endtask

  task automatic wait_seeded(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!seeded && n < 200);
  endtask

  logic [3:0]  v;
  logic [15:0] d;
  logic [15:0] w;
  logic [3:0]  hold_v;
  logic [15:0] hold_d;
  int          t;
  int          nb;
  int          n;
  int          bad_v;
  int          bad_s;
  int          exp_busy;
  int          exp_lat;

  initial begin
    rst_n    = 1'b0;
    seed_req = 1'b0;
    seed     = 16'hACE1;
    req      = 4'h0;
    rdy      = 4'h0;
    m_seed   = 16'hACE1;
    m_state  = 16'h0;
    m_last   = 16'h0;
    m_words  = 0;
`ifdef LFSR_SCHED_RESEED_EN
    exp_busy = 49;
    exp_lat  = 52;
`else
    exp_busy = 16;
    exp_lat  = 18;
`endif
    #3;
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_seeded", 32'(seeded), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    req = 4'hF;
    rdy = 4'hF;
    bad_v = 0;
    bad_s = 0;
    repeat (100) begin
      tick();
      if (valid != 4'h0) bad_v++;
      if (seeded) bad_s++;
    end
    check("t1_no_valid", 32'(bad_v), 32'h0);
    check("t1_no_seeded", 32'(bad_s), 32'h0);

    req = 4'h0;
    rdy = 4'b0001;
    seed_req = 1'b1;
    tick();
    seed_req = 1'b0;
    check("t2_busy_seed", 32'(busy), 32'h1);
    wait_seeded(n);
    check("t2_seeded_lat", 32'(n), 32'd33);
    check("t2_busy_arb", 32'(busy), 32'h0);
    m_load(16'hACE1);
    req = 4'b0001;
    get_word(v, d, t, nb);
    m_next(w);
    check("t2_lat", 32'(t), 32'd17);
    check("t2_grant", 32'(v), 32'h1);
    check("t2_data", 32'(d), 32'(w));
    req = 4'h0;
    tick();
    check("t2_valid_drop", 32'(valid), 32'h0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seed_req = 1'b1;
    tick();
    seed_req = 1'b0;
    wait_seeded(n);
    check("t3_seeded_lat", 32'(n), 32'd33);
    m_load(16'hACE1);
    req = 4'hF;
    rdy = 4'hF;
    for (int i = 0; i < 5; i++) begin
      get_word(v, d, t, nb);
      m_next(w);
      check($sformatf("t3_grant%0d", i), 32'(v),
            32'(4'b0001 << (i % 4)));
      check($sformatf("t3_data%0d", i), 32'(d), 32'(w));
      if (i == 0) check("t3_lat0", 32'(t), 32'd17);
      if (i > 0 && i < 4)
        check($sformatf("t3_space%0d", i), 32'(t), 32'd18);
      if (i == 4) begin
        check("t5_busy_cycles", 32'(nb), 32'(exp_busy));
        check("t5_lat", 32'(t), 32'(exp_lat));
      end
      if (i == 4) rdy = 4'h0;
    end

    hold_v = valid;
    hold_d = data;
    bad_v = 0;
    repeat (50) begin
      tick();
      if (valid !== hold_v || data !== hold_d || busy) bad_v++;
    end
    check("t4_hold", 32'(bad_v), 32'h0);
    check("t4_hold_valid", 32'(valid), 32'h1);
    rdy = 4'hF;
    get_word(v, d, t, nb);
    m_next(w);
    check("t4_grant", 32'(v), 32'h2);
    check("t4_data", 32'(d), 32'(w));
    check("t4_lat", 32'(t), 32'd18);

    rdy = 4'h0;
    repeat (3) tick();
    check("t4_pending", 32'(valid), 32'h2);
    seed = 16'h1234;
    m_seed = 16'h1234;
    seed_req = 1'b1;
    tick();
    seed_req = 1'b0;
    check("t4_seed_drop", 32'(valid), 32'h0);
    check("t4_seed_busy", 32'(busy), 32'h1);
    m_load(16'h1234);
    rdy = 4'hF;
    get_word(v, d, t, nb);
    m_next(w);
    check("t4_reseed_lat", 32'(t), 32'd50);
    check("t4_reseed_grant", 32'(v), 32'h2);
    check("t4_reseed_data", 32'(d), 32'(w));
    check("t4_still_seeded", 32'(seeded), 32'h1);

    repeat (3) tick();
    check("t6_busy_step", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(valid), 32'h0);
    check("t6_rst_data", 32'(data), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_seeded", 32'(seeded), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
